pwl_activation_pipe: RTL and testbench

Parametrised piecewise-linear activation unit: y = m[k]·x + c[k], with segment k chosen by comparing x against a runtime-loadable breakpoint table. Generalises the fixed 9-segment softplus pipeline to any width, fraction and segment count. Adds a valid/ready stream with backpressure, a host coefficient-load port and a bypass mode. Sits between a MAC/accumulator output and the next layer's input buffer.

---
 rtl/pwl_activation_pipe_pkg.sv | 87 ++++++++
 rtl/pwl_segment_select.sv | 38 +++
 rtl/pwl_activation_pipe.sv | 162 ++++++++++++++++
 tb/tb_pwl_activation_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwl_activation_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwl_activation_pipe_pkg
// Brief    : Sign-magnitude fixed-point helpers and config encodings shared
//            by the activation blocks.
// Revision : 1.0
// ============================================================================
package pwl_activation_pipe_pkg;

  // Helpers work on a 32-bit container; callers pass their real width.
  localparam int c_sm_maxw = 32;

  typedef logic [c_sm_maxw-1:0]     sm_word_t;
  typedef logic signed [c_sm_maxw:0] sm_int_t;

  typedef enum logic [1:0] {
    CFG_SEL_BP    = 2'd0,
    CFG_SEL_SLOPE = 2'd1,
    CFG_SEL_ICPT  = 2'd2,
    CFG_SEL_NONE  = 2'd3
  } cfg_sel_e;

  // Largest representable magnitude, 2^(width-1)-1.
  function automatic sm_word_t sm_max_mag(input int width);
    return (sm_word_t'(1) << (width - 1)) - sm_word_t'(1);
  endfunction

  function automatic sm_word_t sm_sign_bit(input int width);
    return sm_word_t'(1) << (width - 1);
  endfunction

  function automatic sm_word_t sm_mag(input sm_word_t v, input int width);
    return v & sm_max_mag(width);
  endfunction

  function automatic logic sm_sign(input sm_word_t v, input int width);
    return (v & sm_sign_bit(width)) != '0;
  endfunction

  // Two's-complement view; -0 and +0 both map to 0.
  function automatic sm_int_t sm_to_int(input sm_word_t v, input int width);
    sm_int_t m;
    m = $signed({1'b0, sm_mag(v, width)});
    return sm_sign(v, width) ? -m : m;
  endfunction

  // Caller guarantees |v| fits; zero always comes back as +0.
  function automatic sm_word_t sm_from_int(input sm_int_t v, input int width);
    sm_int_t  a;
    sm_word_t mag;
    a   = (v < 0) ? -v : v;
    mag = sm_word_t'(a);
    return (v < 0) ? (mag | sm_sign_bit(width)) : mag;
  endfunction

  function automatic logic sm_ge(input sm_word_t a, input sm_word_t b, input int width);
    return sm_to_int(a, width) >= sm_to_int(b, width);
  endfunction

  function automatic sm_word_t sm_mul(input sm_word_t a, input sm_word_t b,
                                      input int width, input int frac);
    logic [2*c_sm_maxw-1:0] p;
    sm_word_t               mag;
    logic                   neg;
    p = ({{c_sm_maxw{1'b0}}, sm_mag(a, width)} * {{c_sm_maxw{1'b0}}, sm_mag(b, width)}) >> frac;
    if (p > {{c_sm_maxw{1'b0}}, sm_max_mag(width)})
      mag = sm_max_mag(width);
    else
      mag = sm_word_t'(p);
    neg = (sm_sign(a, width) ^ sm_sign(b, width)) && (mag != '0);
    return neg ? (mag | sm_sign_bit(width)) : mag;
  endfunction

  function automatic sm_word_t sm_add(input sm_word_t a, input sm_word_t b, input int width);
    sm_int_t s;
    sm_int_t lim;
    lim = $signed({1'b0, sm_max_mag(width)});
    s   = sm_to_int(a, width) + sm_to_int(b, width);
    if (s > lim)
      s = lim;
    else if (s < -lim)
      s = -lim;
    return sm_from_int(s, width);
  endfunction

endpackage : pwl_activation_pipe_pkg
`default_nettype wire

// File: rtl/pwl_segment_select.sv
`default_nettype none
// ============================================================================
// Module   : pwl_segment_select
// Brief    : Combinational segment index: number of breakpoints with x >= bp[i].
// Revision : 1.0
// ============================================================================
module pwl_segment_select
  import pwl_activation_pipe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 9,
  parameter int AW       = $clog2(SEGMENTS)
) (
  input  logic [WIDTH-1:0]              i_x,
  input  logic [(SEGMENTS-1)*WIDTH-1:0] i_bp,
  output logic [AW-1:0]                 o_seg
);

  localparam int c_nbp = SEGMENTS - 1;

  logic [c_nbp-1:0] w_ge;
  logic [AW-1:0]    w_cnt;

  for (genvar i = 0; i < c_nbp; i++) begin : g_cmp
    assign w_ge[i] = sm_ge(sm_word_t'(i_x), sm_word_t'(i_bp[i*WIDTH +: WIDTH]), WIDTH);
  end

  // Population count keeps the result correct even if the table is unsorted.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < c_nbp; i++)
      w_cnt = w_cnt + AW'(w_ge[i]);
  end

  assign o_seg = w_cnt;

endmodule : pwl_segment_select
`default_nettype wire

// File: rtl/pwl_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pwl_activation_pipe
// Brief    : Three-stage piecewise-linear activation y = m[k]*x + c[k] with
//            valid/ready backpressure, runtime table load and bypass.
// Revision : 1.0
// ============================================================================
module pwl_activation_pipe
  import pwl_activation_pipe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 11,
  parameter int SEGMENTS = 9,
  parameter int AW       = $clog2(SEGMENTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_seg,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata
);

  localparam int c_nbp = SEGMENTS - 1;

  logic [WIDTH-1:0]       r_bp [c_nbp];
  logic [WIDTH-1:0]       r_m  [SEGMENTS];
  logic [WIDTH-1:0]       r_c  [SEGMENTS];
  logic [c_nbp*WIDTH-1:0] w_bp_flat;
  cfg_sel_e               w_sel;

  logic [AW-1:0]    w_seg;
  logic [WIDTH-1:0] w_m;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_sum;
  logic             w_en;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_m;
  logic [WIDTH-1:0] r_s1_c;
  logic [AW-1:0]    r_s1_seg;
  logic             r_s1_mode;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_val;
  logic [WIDTH-1:0] r_s2_c;
  logic [AW-1:0]    r_s2_seg;
  logic             r_s2_mode;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [AW-1:0]    r_out_seg;

  assign w_sel = cfg_sel_e'(cfg_sel);

  // Table writes are never blocked by backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_nbp; i++)
        r_bp[i] <= '0;
      for (int i = 0; i < SEGMENTS; i++) begin
        r_m[i] <= '0;
        r_c[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < c_nbp; i++)
        if (w_sel == CFG_SEL_BP && cfg_addr == AW'(i))
          r_bp[i] <= cfg_wdata;
      for (int i = 0; i < SEGMENTS; i++) begin
        if (w_sel == CFG_SEL_SLOPE && cfg_addr == AW'(i))
          r_m[i] <= cfg_wdata;
        if (w_sel == CFG_SEL_ICPT && cfg_addr == AW'(i))
          r_c[i] <= cfg_wdata;
      end
    end
  end

  for (genvar i = 0; i < c_nbp; i++) begin : g_bp_flat
    assign w_bp_flat[i*WIDTH +: WIDTH] = r_bp[i];
  end

  pwl_segment_select #(
    .WIDTH    (WIDTH),
    .SEGMENTS (SEGMENTS),
    .AW       (AW)
  ) u_segment_select (
    .i_x   (in_data),
    .i_bp  (w_bp_flat),
    .o_seg (w_seg)
  );

  always_comb begin
    w_m = '0;
    w_c = '0;
    for (int i = 0; i < SEGMENTS; i++)
      if (w_seg == AW'(i)) begin
        w_m = r_m[i];
        w_c = r_c[i];
      end
  end

  assign w_prod = WIDTH'(sm_mul(sm_word_t'(r_s1_x), sm_word_t'(r_s1_m), WIDTH, FRAC));
  assign w_sum  = WIDTH'(sm_add(sm_word_t'(r_s2_val), sm_word_t'(r_s2_c), WIDTH));

  // Whole pipe advances as one; a held output freezes every stage.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_m      <= '0;
      r_s1_c      <= '0;
      r_s1_seg    <= '0;
      r_s1_mode   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_val    <= '0;
      r_s2_c      <= '0;
      r_s2_seg    <= '0;
      r_s2_mode   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_seg   <= '0;
    end else if (w_en) begin
      r_s1_valid  <= in_valid;
      r_s1_x      <= in_data;
      r_s1_m      <= w_m;
      r_s1_c      <= w_c;
      r_s1_seg    <= mode ? '0 : w_seg;
      r_s1_mode   <= mode;

      r_s2_valid  <= r_s1_valid;
      r_s2_val    <= r_s1_mode ? r_s1_x : w_prod;
      r_s2_c      <= r_s1_c;
      r_s2_seg    <= r_s1_seg;
      r_s2_mode   <= r_s1_mode;

      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data <= r_s2_mode ? r_s2_val : w_sum;
        r_out_seg  <= r_s2_seg;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_seg   = r_out_seg;

endmodule : pwl_activation_pipe
`default_nettype wire

// File: tb/tb_pwl_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwl_activation_pipe
// Brief    : Directed self-checking bench for pwl_activation_pipe.
// Revision : 1.0
// ============================================================================
module tb_pwl_activation_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_seg;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwl_activation_pipe #(
    .WIDTH    (16),
    .FRAC     (11),
    .SEGMENTS (9),
    .AW       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seg   (out_seg),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic load_softplus();
    logic [15:0] bp [8];
    bp = '{16'h9F00, 16'h9237, 16'h89BF, 16'h831B,
           16'h0314, 16'h09C5, 16'h1235, 16'h1EF8};
    for (int i = 0; i < 8; i++)
      cfg_write(2'd0, 4'(i), bp[i]);
    cfg_write(2'd1, 4'd4, 16'h03FF);
    cfg_write(2'd2, 4'd4, 16'h05B1);
    cfg_write(2'd1, 4'd8, 16'h07F5);
    cfg_write(2'd2, 4'd8, 16'h0051);
  endtask

  // One isolated sample; latency counts edges from the accepting edge.
  task automatic run_one(input string tag, input logic [15:0] x, input logic md,
                         input logic [15:0] exp_y, input logic [3:0] exp_seg);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = x;
    mode      = md;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_y"}, out_data, exp_y);
    check({tag, "_seg"}, out_seg, exp_seg);
    @(negedge clk);
  endtask

  // Ten back-to-back samples in segment 8 (m = 1.0, c = 0x0100), stall mid-stream.
  task automatic stream();
    int          n_in;
    int          n_out;
    logic        accepted;
    logic [15:0] exp_y;
    n_in  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 60 && n_out < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid  = (n_in < 10);
      in_data   = 16'h2000 + 16'(n_in) * 16'h0010;
      mode      = 1'b0;
      #1;
      exp_y = 16'h2100 + 16'(n_out) * 16'h0010;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_hold", out_data, exp_y);
      end
      if (out_valid && out_ready) begin
        check("strm_y", out_data, exp_y);
        check("strm_seg", out_seg, 8);
        n_out++;
      end
      accepted = in_valid && in_ready;
      @(posedge clk);
      if (accepted)
        n_in++;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("strm_out_count", n_out, 10);
    check("strm_in_count", n_in, 10);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("strm_drain", out_valid, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_seg", out_seg, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Empty table: every breakpoint is 0, so x >= all of them, y = 0.
    run_one("zero_tbl", 16'h1234, 1'b0, 16'h0000, 4'd8);

    load_softplus();
    run_one("pos0", 16'h0000, 1'b0, 16'h05B1, 4'd4);
    run_one("neg0", 16'h8000, 1'b0, 16'h05B1, 4'd4);
    run_one("max", 16'h7FFF, 1'b0, 16'h7FA0, 4'd8);

    cfg_write(2'd3, 4'd4, 16'h1234);
    cfg_write(2'd2, 4'hC, 16'h7000);
    run_one("ignored_wr", 16'h0000, 1'b0, 16'h05B1, 4'd4);

    cfg_write(2'd1, 4'd8, 16'h0800);
    cfg_write(2'd2, 4'd8, 16'h0100);
    run_one("sat", 16'h7FFF, 1'b0, 16'h7FFF, 4'd8);

    // x = -1.0 lands in segment 3; product -0x0200.
    cfg_write(2'd1, 4'd3, 16'h0200);
    cfg_write(2'd2, 4'd3, 16'h0300);
    run_one("neg_x", 16'h8800, 1'b0, 16'h0100, 4'd3);
    cfg_write(2'd2, 4'd3, 16'h8100);
    run_one("neg_sum", 16'h8800, 1'b0, 16'h8300, 4'd3);
    cfg_write(2'd2, 4'd3, 16'h0200);
    run_one("zero_sum", 16'h8800, 1'b0, 16'h0000, 4'd3);

    run_one("bypass", 16'h8123, 1'b1, 16'h8123, 4'd0);

    stream();

    // Three samples in flight, then asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    mode     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    @(posedge clk);
    #1;
    check("mid_rst_valid_next", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", out_valid, 0);
    end
    run_one("rst_tbl", 16'h0000, 1'b0, 16'h0000, 4'd8);
    load_softplus();
    run_one("reload0", 16'h0000, 1'b0, 16'h05B1, 4'd4);
    run_one("reload_max", 16'h7FFF, 1'b0, 16'h7FA0, 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pwl_activation_pipe
`default_nettype wire
